// File: rtl/interboard_tx_engine.sv
// Four-phase transmitter: sends a 24-bit control packet to the peer board as four
// 6-bit words, each handshaked on Request_out/Ack_in, with a per-phase timeout.
module interboard_tx_engine #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       transmit,
    input  logic       ctrl_en,
    input  logic       ctrl_move_dir,
    input  logic [4:0] ctrl_block_x,
    input  logic [2:0] ctrl_block_y,
    input  logic [3:0] ctrl_msg_type,
    input  logic [5:0] ctrl_card,
    input  logic [2:0] ctrl_sel_len,
    input  logic       Ack_in,
    output logic       Request_out,
    output logic [5:0] inter_data_out,
    output logic       send_ready,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SETUP, REQ_HIGH, REQ_LOW, DONE, ERROR} state_t;

    state_t           state;
    logic [23:0]      packet;
    logic [23:0]      fields;
    logic [1:0]       index;
    logic [CNT_W-1:0] count;
    logic             ack_meta;
    logic             ack_s;

    assign fields = {ctrl_en, ctrl_move_dir, ctrl_block_x, ctrl_block_y,
                     ctrl_msg_type, ctrl_card, ctrl_sel_len, 1'b0};

    function automatic logic [5:0] word_at(input logic [23:0] pkt, input logic [1:0] k);
        case (k)
            2'd0:    return pkt[23:18];
            2'd1:    return pkt[17:12];
            2'd2:    return pkt[11:6];
            default: return pkt[5:0];
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= Ack_in;
            ack_s    <= ack_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            packet         <= '0;
            index          <= '0;
            count          <= '0;
            Request_out    <= 1'b0;
            inter_data_out <= '0;
            send_ready     <= 1'b1;
            tx_done        <= 1'b0;
            tx_error       <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (transmit) begin
                        packet         <= fields;
                        index          <= '0;
                        inter_data_out <= fields[23:18];
                        send_ready     <= 1'b0;
                        state          <= SETUP;
                    end
                end
                SETUP: begin
                    Request_out <= 1'b1;
                    count       <= '0;
                    state       <= REQ_HIGH;
                end
                REQ_HIGH: begin
                    // A level already high on entry counts as the acknowledge.
                    if (ack_s) begin
                        Request_out <= 1'b0;
                        count       <= '0;
                        state       <= REQ_LOW;
                    end else if (count == CNT_LAST) begin
                        Request_out <= 1'b0;
                        tx_error    <= 1'b1;
                        state       <= ERROR;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                REQ_LOW: begin
                    if (!ack_s) begin
                        if (index == 2'd3) begin
                            tx_done <= 1'b1;
                            state   <= DONE;
                        end else begin
                            index          <= index + 2'd1;
                            inter_data_out <= word_at(packet, index + 2'd1);
                            state          <= SETUP;
                        end
                    end else if (count == CNT_LAST) begin
                        tx_error <= 1'b1;
                        state    <= ERROR;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    send_ready <= 1'b1;
                    state      <= IDLE;
                end
                ERROR: begin
                    send_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_interboard_tx_engine.sv
// Bench for interboard_tx_engine: table vectors, random messages against a packet model,
// and hand-written busy / timeout / stuck-ack / reset sequences.
module tb_interboard_tx_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       transmit = 1'b0;
    logic       ctrl_en = 1'b0;
    logic       ctrl_move_dir = 1'b0;
    logic [4:0] ctrl_block_x = '0;
    logic [2:0] ctrl_block_y = '0;
    logic [3:0] ctrl_msg_type = '0;
    logic [5:0] ctrl_card = '0;
    logic [2:0] ctrl_sel_len = '0;
    logic       Ack_in;
    logic       Request_out;
    logic [5:0] inter_data_out;
    logic       send_ready;
    logic       tx_done;
    logic       tx_error;

    interboard_tx_engine #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .transmit(transmit),
        .ctrl_en(ctrl_en), .ctrl_move_dir(ctrl_move_dir),
        .ctrl_block_x(ctrl_block_x), .ctrl_block_y(ctrl_block_y),
        .ctrl_msg_type(ctrl_msg_type), .ctrl_card(ctrl_card), .ctrl_sel_len(ctrl_sel_len),
        .Ack_in(Ack_in), .Request_out(Request_out), .inter_data_out(inter_data_out),
        .send_ready(send_ready), .tx_done(tx_done), .tx_error(tx_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       dir;
        logic [4:0] x;
        logic [2:0] y;
        logic [3:0] typ;
        logic [5:0] card;
        logic [2:0] sel;
        logic [23:0] words;   // {word0, word1, word2, word3}
    } vec_t;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Peer board: 0 = four-phase follower with random delay, 1 = hold low, 2 = hold high
    int unsigned resp_mode = 1;
    int unsigned resp_wait = 0;
    initial begin
        Ack_in = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_mode == 1) Ack_in = 1'b0;
            else if (resp_mode == 2) Ack_in = 1'b1;
            else if (Request_out !== Ack_in) begin
                if (resp_wait == 0) begin
                    Ack_in = Request_out;
                    resp_wait = $urandom_range(0, 10);
                end else begin
                    resp_wait--;
                end
            end
        end
    end

    // Passive monitor: records each Request rise/fall and pulse counts
    logic [5:0]  got_w[$];
    bit          got_stable[$];
    bit          got_ack_ok[$];
    bit          got_fall_ok[$];
    int unsigned rise_cyc[$];
    int unsigned fall_cyc[$];
    int unsigned done_cnt = 0, err_cnt = 0, cyc = 0, ack_hi = 0, ack_lo = 0;
    logic        prev_req = 1'b0;
    logic [5:0]  prev_data = '0;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (Request_out === 1'b1 && prev_req === 1'b0) begin
                got_w.push_back(inter_data_out);
                got_stable.push_back(prev_data === inter_data_out);
                got_ack_ok.push_back(ack_lo >= 4);
                rise_cyc.push_back(cyc);
            end
            if (Request_out === 1'b0 && prev_req === 1'b1) begin
                got_fall_ok.push_back(ack_hi >= 3);
                fall_cyc.push_back(cyc);
            end
            if (tx_done === 1'b1) done_cnt++;
            if (tx_error === 1'b1) err_cnt++;
            if (Ack_in === 1'b1) begin
                ack_hi++;
                ack_lo = 0;
            end else begin
                ack_lo++;
                ack_hi = 0;
            end
            prev_req = Request_out;
            prev_data = inter_data_out;
        end
    end

    function automatic logic [5:0] model_word(input vec_t v, input int unsigned k);
        logic [23:0] packet;
        packet = {v.en, v.dir, v.x, v.y, v.typ, v.card, v.sel, 1'b0};
        return packet[23 - 6 * k -: 6];
    endfunction

    function automatic vec_t random_vec();
        vec_t v;
        v.en = 1'($urandom);
        v.dir = 1'($urandom);
        v.x = 5'($urandom);
        v.y = 3'($urandom);
        v.typ = 4'($urandom);
        v.card = 6'($urandom);
        v.sel = 3'($urandom);
        for (int unsigned k = 0; k < 4; k++) v.words[23 - 6 * k -: 6] = model_word(v, k);
        return v;
    endfunction

    task automatic drive_fields(input vec_t v);
        ctrl_en = v.en;
        ctrl_move_dir = v.dir;
        ctrl_block_x = v.x;
        ctrl_block_y = v.y;
        ctrl_msg_type = v.typ;
        ctrl_card = v.card;
        ctrl_sel_len = v.sel;
    endtask

    task automatic start_msg(input vec_t v);
        vec_t junk;
        @(negedge clk);
        drive_fields(v);
        transmit = 1'b1;
        @(negedge clk);
        transmit = 1'b0;
        junk = random_vec();
        drive_fields(junk);
    endtask

    task automatic wait_ready(input string tag);
        int unsigned n = 0;
        while (send_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready_before"}, 32'(send_ready), 32'd1);
    endtask

    task automatic wait_end(input string tag, input int unsigned d0, input int unsigned e0);
        int unsigned n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_end_in_time"}, 32'(n < 400), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_words(input string tag, input int unsigned w0, input int unsigned f0,
                               input logic [23:0] exp, input int unsigned nwords, input bit hs);
        chk({tag, "_word_count"}, 32'(got_w.size() - w0), 32'(nwords));
        for (int unsigned k = 0; k < nwords; k++) begin
            if (got_w.size() > w0 + k) begin
                chk($sformatf("%s_w%0d", tag, k), 32'(got_w[w0 + k]), 32'(exp[23 - 6 * k -: 6]));
                chk($sformatf("%s_setup%0d", tag, k), 32'(got_stable[w0 + k]), 32'd1);
                if (hs) begin
                    chk($sformatf("%s_rise_after_ack_low%0d", tag, k), 32'(got_ack_ok[w0 + k]), 32'd1);
                    if (got_fall_ok.size() > f0 + k)
                        chk($sformatf("%s_fall_after_ack_high%0d", tag, k),
                            32'(got_fall_ok[f0 + k]), 32'd1);
                end
            end
        end
    endtask

    task automatic run_message(input string tag, input vec_t v);
        int unsigned w0, f0, d0, e0;
        wait_ready(tag);
        w0 = got_w.size();
        f0 = got_fall_ok.size();
        d0 = done_cnt;
        e0 = err_cnt;
        start_msg(v);
        wait_end(tag, d0, e0);
        check_words(tag, w0, f0, v.words, 4, 1'b1);
        chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_error_pulses"}, 32'(err_cnt - e0), 32'd0);
        chk({tag, "_ready_after"}, 32'(send_ready), 32'd1);
    endtask

    vec_t tbl[4];

    initial begin
        vec_t v, v2;
        int unsigned w0, f0, r0, d0, e0, n;

        tbl[0] = '{1'b1, 1'b0, 5'd7, 3'd2, 4'h3, 6'd45, 3'd4,
                   {6'b100011, 6'b101000, 6'b111011, 6'b011000}};
        tbl[1] = '{1'b0, 1'b0, 5'd0, 3'd0, 4'h0, 6'd0, 3'd0, 24'h000000};
        tbl[2] = '{1'b1, 1'b1, 5'd31, 3'd7, 4'hF, 6'd63, 3'd7,
                   {6'b111111, 6'b111111, 6'b111111, 6'b111110}};
        tbl[3] = '{1'b0, 1'b1, 5'b10101, 3'b010, 4'hA, 6'b010101, 3'b101,
                   {6'b011010, 6'b101010, 6'b100101, 6'b011010}};

        // Reset state, with transmit asserted alongside reset
        drive_fields(tbl[0]);
        transmit = 1'b1;
        @(negedge clk);
        chk("rst_request", 32'(Request_out), 32'd0);
        chk("rst_data", 32'(inter_data_out), 32'd0);
        chk("rst_ready", 32'(send_ready), 32'd1);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_error", 32'(tx_error), 32'd0);
        rst = 1'b0;
        transmit = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_beats_transmit_rises", 32'(got_w.size()), 32'd0);
        chk("rst_beats_transmit_ready", 32'(send_ready), 32'd1);

        resp_mode = 0;
        for (int unsigned i = 0; i < 4; i++) run_message($sformatf("tbl%0d", i), tbl[i]);
        for (int unsigned i = 0; i < 20; i++) run_message($sformatf("rnd%0d", i), random_vec());

        // Second transmit while word 1 is in flight must be ignored
        v = random_vec();
        v2 = v;
        v2.card = 6'd1;
        w0 = got_w.size();
        f0 = got_fall_ok.size();
        d0 = done_cnt;
        e0 = err_cnt;
        start_msg(v);
        n = 0;
        while (got_w.size() < w0 + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("busy_reach_word1", 32'(n < 200), 32'd1);
        drive_fields(v2);
        transmit = 1'b1;
        @(negedge clk);
        transmit = 1'b0;
        wait_end("busy", d0, e0);
        repeat (20) @(negedge clk);
        check_words("busy", w0, f0, v.words, 4, 1'b1);
        chk("busy_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("busy_error_pulses", 32'(err_cnt - e0), 32'd0);

        // Ack never arrives: Request held for the full timeout, then abort
        resp_mode = 1;
        repeat (4) @(negedge clk);
        v = random_vec();
        w0 = got_w.size();
        f0 = got_fall_ok.size();
        r0 = rise_cyc.size();
        d0 = done_cnt;
        e0 = err_cnt;
        start_msg(v);
        wait_end("tmo", d0, e0);
        check_words("tmo", w0, f0, v.words, 1, 1'b0);
        if (fall_cyc.size() > f0 && rise_cyc.size() > r0)
            chk("tmo_request_high_cycles", 32'(fall_cyc[f0] - rise_cyc[r0]), 32'd16);
        else
            chk("tmo_request_fell", 32'(fall_cyc.size() - f0), 32'd1);
        chk("tmo_error_pulses", 32'(err_cnt - e0), 32'd1);
        chk("tmo_done_pulses", 32'(done_cnt - d0), 32'd0);
        chk("tmo_ready", 32'(send_ready), 32'd1);

        // Ack stuck high: word 0 acknowledged at once, release phase times out
        resp_mode = 2;
        repeat (5) @(negedge clk);
        v = random_vec();
        w0 = got_w.size();
        f0 = got_fall_ok.size();
        r0 = rise_cyc.size();
        d0 = done_cnt;
        e0 = err_cnt;
        start_msg(v);
        wait_end("stuck", d0, e0);
        check_words("stuck", w0, f0, v.words, 1, 1'b0);
        if (fall_cyc.size() > f0 && rise_cyc.size() > r0)
            chk("stuck_request_high_cycles", 32'(fall_cyc[f0] - rise_cyc[r0]), 32'd1);
        chk("stuck_error_pulses", 32'(err_cnt - e0), 32'd1);
        chk("stuck_done_pulses", 32'(done_cnt - d0), 32'd0);
        chk("stuck_ready", 32'(send_ready), 32'd1);
        resp_mode = 1;
        repeat (5) @(negedge clk);

        // Reset while word 2 is being requested
        resp_mode = 0;
        v = random_vec();
        w0 = got_w.size();
        d0 = done_cnt;
        e0 = err_cnt;
        start_msg(v);
        n = 0;
        while (got_w.size() < w0 + 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rstmid_reach_word2", 32'(n < 200), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_request", 32'(Request_out), 32'd0);
        chk("rstmid_data", 32'(inter_data_out), 32'd0);
        chk("rstmid_ready", 32'(send_ready), 32'd1);
        repeat (30) @(negedge clk);
        chk("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
        chk("rstmid_no_error", 32'(err_cnt - e0), 32'd0);
        chk("rstmid_no_more_words", 32'(got_w.size() - w0), 32'd3);
        run_message("after_rst", tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
